// File: rtl/bldc_commutator_pkg.sv
// Shared types for the BLDC commutator: FSM states, gate-pattern struct and the
// six-step commutation table keyed by hall code and rotation direction.
package bldc_commutator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FAULT = 3'd3
  } state_e;

  localparam logic [2:0] HALL_BAD_LO = 3'b000;
  localparam logic [2:0] HALL_BAD_HI = 3'b111;

  typedef struct packed {
    logic [2:0] h;
    logic [2:0] l;
  } gate_pat_t;

  function automatic logic hall_valid(input logic [2:0] code);
    return (code != HALL_BAD_LO) && (code != HALL_BAD_HI);
  endfunction

  // Forward table; reverse rotation swaps the high and low phase.
  function automatic gate_pat_t comm_pattern(input logic [2:0] code, input logic dir);
    gate_pat_t fwd;
    gate_pat_t res;
    fwd = '0;
    case (code)
      3'b101: begin fwd.h = 3'b001; fwd.l = 3'b010; end
      3'b100: begin fwd.h = 3'b001; fwd.l = 3'b100; end
      3'b110: begin fwd.h = 3'b010; fwd.l = 3'b100; end
      3'b010: begin fwd.h = 3'b010; fwd.l = 3'b001; end
      3'b011: begin fwd.h = 3'b100; fwd.l = 3'b001; end
      3'b001: begin fwd.h = 3'b100; fwd.l = 3'b010; end
      default: fwd = '0;
    endcase
    res.h = dir ? fwd.l : fwd.h;
    res.l = dir ? fwd.h : fwd.l;
    return res;
  endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall input conditioning: two-flop synchroniser followed by a debounce that
// accepts a code only after HALL_FILT consecutive identical samples.
module bldc_commutator_hall_filter #(
  parameter int HALL_FILT = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] hall_i,
  output logic [2:0] code_o,
  output logic       chg_o
);

  localparam int RUN_W = $clog2(HALL_FILT + 1);

  logic [2:0]       sync1_q, sync2_q, last_q, code_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             chg_q, accept;

  // Run length saturates at HALL_FILT so a stable input never wraps the count.
  always_comb begin
    run_d = RUN_W'(1);
    if (sync2_q == last_q) begin
      run_d = (run_q == RUN_W'(HALL_FILT)) ? run_q : run_q + 1'b1;
    end
    accept = (run_d == RUN_W'(HALL_FILT)) && (sync2_q != code_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      run_q   <= '0;
      code_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      run_q   <= run_d;
      chg_q   <= accept;
      if (accept) code_q <= sync2_q;
    end
  end

  assign code_o = code_q;
  assign chg_o  = chg_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation sequencer: hall-driven FSM with dead-time, soft-start
// duty ramp for the external PWM modulator, stall detection and registered gates.
module bldc_commutator
  import bldc_commutator_pkg::*;
#(
  parameter int DUTY_W    = 4,
  parameter int DEADTIME  = 8,
  parameter int RAMP_DIV  = 1024,
  parameter int HALL_FILT = 3,
  parameter int STALL_CYC = 2**20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic [DUTY_W-1:0] duty_tgt_i,
  input  logic [2:0]        hall_i,
  input  logic              pwm_in_i,
  output logic [DUTY_W-1:0] duty_out_o,
  output logic              pwm_en_o,
  output logic [2:0]        gate_h_o,
  output logic [2:0]        gate_l_o,
  output logic              fault_o,
  output logic [2:0]        state_o
);

  localparam int DEAD_W  = $clog2(DEADTIME + 1);
  localparam int RAMP_W  = $clog2(RAMP_DIV + 1);
  localparam int STALL_W = $clog2(STALL_CYC + 1);

  state_e              state_q, state_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                dir_q, dir_d;
  logic [2:0]          gate_h_q, gate_h_d, gate_l_q, gate_l_d;
  logic [2:0]          code;
  logic                chg, code_ok, stall_hit, run_next, ramp_active;
  gate_pat_t           pat;

  bldc_commutator_hall_filter #(.HALL_FILT(HALL_FILT)) u_hall_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hall_i (hall_i),
    .code_o (code),
    .chg_o  (chg)
  );

  assign code_ok   = hall_valid(code);
  assign pat       = comm_pattern(code, dir_i);
  assign stall_hit = (state_q == ST_RUN) && (stall_q == STALL_W'(STALL_CYC));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_i && code_ok) state_d = ST_DEAD;
      ST_DEAD: begin
        if (!code_ok) state_d = ST_FAULT;
        else if (!chg && dead_q == DEAD_W'(DEADTIME - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!code_ok || stall_hit) state_d = ST_FAULT;
        else if (chg || dir_i != dir_q) state_d = ST_DEAD;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    // Dropping EN overrides everything, including a fault raised this cycle.
    if (!en_i) state_d = ST_IDLE;
  end

  // A fresh code while in DEAD restarts the dead-time window.
  assign dead_d = (state_q == ST_DEAD && !chg) ? dead_q + 1'b1 : '0;

  assign ramp_active = (state_d == ST_DEAD) || (state_d == ST_RUN);

  always_comb begin
    ramp_d = '0;
    duty_d = '0;
    if (ramp_active) begin
      duty_d = duty_q;
      if (ramp_q == RAMP_W'(RAMP_DIV - 1)) begin
        if (duty_q < duty_tgt_i)      duty_d = duty_q + 1'b1;
        else if (duty_q > duty_tgt_i) duty_d = duty_q - 1'b1;
      end else begin
        ramp_d = ramp_q + 1'b1;
      end
    end
  end

  // Zero duty means no torque, so a motionless rotor is not a stall then.
  assign stall_d = (state_q != ST_RUN || chg || duty_q == '0) ? '0 :
                   (stall_q == STALL_W'(STALL_CYC)) ? stall_q : stall_q + 1'b1;

  assign run_next = (state_d == ST_RUN);
  assign dir_d    = run_next ? dir_i : dir_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    assign gate_h_d[gi] = run_next & pat.h[gi] & pwm_in_i;
    assign gate_l_d[gi] = run_next & pat.l[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      dead_q   <= '0;
      ramp_q   <= '0;
      duty_q   <= '0;
      stall_q  <= '0;
      dir_q    <= 1'b0;
      gate_h_q <= '0;
      gate_l_q <= '0;
    end else begin
      state_q  <= state_d;
      dead_q   <= dead_d;
      ramp_q   <= ramp_d;
      duty_q   <= duty_d;
      stall_q  <= stall_d;
      dir_q    <= dir_d;
      gate_h_q <= gate_h_d;
      gate_l_q <= gate_l_d;
    end
  end

  assign duty_out_o = duty_q;
  assign pwm_en_o   = (state_q == ST_DEAD) || (state_q == ST_RUN);
  assign gate_h_o   = gate_h_q;
  assign gate_l_o   = gate_l_q;
  assign fault_o    = (state_q == ST_FAULT);
  assign state_o    = state_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator: random PWM chopping, commutation
// sequences, glitch, invalid-code, stall, ramp and asynchronous reset scenarios.
module tb_bldc_commutator;

  localparam int DUTY_W    = 4;
  localparam int DEADTIME  = 4;
  localparam int RAMP_DIV  = 8;
  localparam int HALL_FILT = 3;
  localparam int STALL_CYC = 200;
  localparam int HOLD      = 6;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FAULT = 3'd3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              dir = 1'b0;
  logic              pwm = 1'b0;
  logic [DUTY_W-1:0] duty_tgt = '0;
  logic [2:0]        hall = 3'b000;
  logic [DUTY_W-1:0] duty_out;
  logic              pwm_en;
  logic [2:0]        gate_h, gate_l, state;
  logic              fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bldc_commutator #(
    .DUTY_W(DUTY_W), .DEADTIME(DEADTIME), .RAMP_DIV(RAMP_DIV),
    .HALL_FILT(HALL_FILT), .STALL_CYC(STALL_CYC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .duty_tgt_i(duty_tgt),
    .hall_i(hall), .pwm_in_i(pwm), .duty_out_o(duty_out), .pwm_en_o(pwm_en),
    .gate_h_o(gate_h), .gate_l_o(gate_l), .fault_o(fault), .state_o(state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference table written as phase indices (0=A, 1=B, 2=C): high phase and low phase.
  function automatic logic [5:0] model_pat(input logic [2:0] code, input logic d);
    int hi = 0;
    int lo = 0;
    int t;
    case (code)
      3'b101: begin hi = 0; lo = 1; end
      3'b100: begin hi = 0; lo = 2; end
      3'b110: begin hi = 1; lo = 2; end
      3'b010: begin hi = 1; lo = 0; end
      3'b011: begin hi = 2; lo = 0; end
      3'b001: begin hi = 2; lo = 1; end
      default: return 6'b0;
    endcase
    if (d) begin t = hi; hi = lo; lo = t; end
    return {3'(1 << hi), 3'(1 << lo)};
  endfunction

  logic              pwm_edge = 1'b0;
  logic [DUTY_W-1:0] tgt_edge = '0;
  always @(posedge clk) begin
    pwm_edge <= pwm;
    tgt_edge <= duty_tgt;
  end

  initial forever begin
    @(negedge clk);
    pwm = 1'($urandom);
  end

  bit                mon_en = 1'b0;
  bit                chk_run = 1'b0;
  bit                gap_ok = 1'b0;
  logic [2:0]        exp_h = '0, exp_l = '0;
  logic [DUTY_W-1:0] prev_duty = '0;
  logic [DUTY_W-1:0] toward;
  int                since = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("shoot", 32'(gate_h & gate_l), 0);
      check_eq("onehot", 32'(($countones(gate_h) <= 1) && ($countones(gate_l) <= 1)), 1);
      check_eq("pwm_en", 32'(pwm_en), 32'(state == S_DEAD || state == S_RUN));
      check_eq("gates_off", 32'((state != S_RUN) && ((gate_h | gate_l) != 0)), 0);
      if (state == S_DEAD || state == S_RUN) begin
        since++;
        if (duty_out != prev_duty) begin
          toward = (tgt_edge > prev_duty) ? prev_duty + 1'b1 :
                   (tgt_edge < prev_duty) ? prev_duty - 1'b1 : prev_duty;
          check_eq("ramp_dir", 32'(duty_out), 32'(toward));
          if (gap_ok) check_eq("ramp_gap", since, RAMP_DIV);
          since  = 0;
          gap_ok = (duty_out != tgt_edge);
        end else if (duty_out == tgt_edge) begin
          gap_ok = 1'b0;
        end
      end else begin
        check_eq("duty_off", 32'(duty_out), 0);
        gap_ok = 1'b0;
      end
      if (chk_run) begin
        check_eq("gate_l", 32'(gate_l), 32'(exp_l));
        check_eq("gate_h", 32'(gate_h), 32'(exp_h & {3{pwm_edge}}));
      end
    end
    prev_duty = duty_out;
  end

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(state), 32'(st));
  endtask

  task automatic commutate(input logic [2:0] code, input logic d);
    int n = 0;
    chk_run = 1'b0;
    hall = code;
    dir = d;
    wait_state(S_DEAD, 20, "to_dead");
    while (state == S_DEAD && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("dead_len", n, DEADTIME);
    check_eq("to_run", 32'(state), 32'(S_RUN));
    {exp_h, exp_l} = model_pat(code, d);
    chk_run = (state == S_RUN);
    repeat (HOLD) @(negedge clk);
  endtask

  logic [2:0] seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  initial begin
    int t;
    int dn;
    int k;
    hall = 3'b101;
    duty_tgt = 4'd15;
    repeat (3) @(negedge clk);
    check_eq("rst_duty", 32'(duty_out), 0);
    check_eq("rst_pwm_en", 32'(pwm_en), 0);
    check_eq("rst_gates", 32'({gate_h, gate_l}), 0);
    check_eq("rst_fault", 32'(fault), 0);
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    rst_n = 1'b1;
    mon_en = 1'b1;
    en = 1'b1;

    // Start-up: dead time, first pattern A+B-, ramp to 15.
    wait_state(S_DEAD, 20, "start_dead");
    t = 0;
    dn = 0;
    while (duty_out != 4'd15 && t < 300) begin
      if (state == S_DEAD) dn++;
      if (state == S_RUN && !chk_run) begin
        exp_h = 3'b001;
        exp_l = 3'b010;
        chk_run = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    check_eq("start_dead_len", dn, DEADTIME);
    check_eq("ramp_time", 32'(t >= 112 && t <= 124), 1);

    for (int i = 0; i < 6; i++) commutate(seq[i], 1'b0);
    commutate(3'b101, 1'b1);
    for (int i = 0; i < 5; i++) commutate(seq[i], 1'b1);

    // Glitch: one-cycle pulse must not commutate.
    commutate(3'b001, 1'b0);
    commutate(3'b101, 1'b0);
    hall = 3'b100;
    @(negedge clk);
    hall = 3'b101;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("glitch_state", 32'(state), 32'(S_RUN));
    end

    // Stall with duty > 0.
    commutate(3'b100, 1'b0);
    t = HOLD;
    while (!fault && t < 400) begin
      if (t == 180) chk_run = 1'b0;
      @(negedge clk);
      t++;
    end
    check_eq("stall_time", 32'(t >= 195 && t <= 210), 1);
    check_eq("stall_state", 32'(state), 32'(S_FAULT));
    check_eq("stall_gates", 32'(gate_h | gate_l), 0);
    check_eq("stall_duty", 32'(duty_out), 0);
    check_eq("stall_pwm_en", 32'(pwm_en), 0);
    en = 1'b0;
    @(negedge clk);
    check_eq("clr_state", 32'(state), 32'(S_IDLE));
    check_eq("clr_fault", 32'(fault), 0);

    // Invalid code in RUN.
    en = 1'b1;
    commutate(3'b100, 1'b0);
    chk_run = 1'b0;
    hall = 3'b111;
    wait_state(S_FAULT, 20, "inv_state");
    check_eq("inv_fault", 32'(fault), 1);
    check_eq("inv_gates", 32'(gate_h | gate_l), 0);
    check_eq("inv_duty", 32'(duty_out), 0);
    en = 1'b0;
    @(negedge clk);
    check_eq("inv_clr_state", 32'(state), 32'(S_IDLE));
    check_eq("inv_clr_fault", 32'(fault), 0);
    hall = 3'b101;
    en = 1'b1;
    commutate(3'b101, 1'b0);

    // Zero target: frozen hall must not stall-fault.
    chk_run = 1'b0;
    en = 1'b0;
    duty_tgt = 4'd0;
    @(negedge clk);
    en = 1'b1;
    commutate(3'b101, 1'b0);
    repeat (300) @(negedge clk);
    check_eq("zero_fault", 32'(fault), 0);
    check_eq("zero_state", 32'(state), 32'(S_RUN));
    check_eq("zero_duty", 32'(duty_out), 0);

    // Ramp up to 15 while commutating, then retarget down to 3.
    duty_tgt = 4'd15;
    k = 0;
    while (duty_out != 4'd15 && k < 30) begin
      commutate(seq[k % 6], 1'b0);
      k++;
    end
    check_eq("up_duty", 32'(duty_out), 15);
    duty_tgt = 4'd3;
    while (duty_out != 4'd3 && k < 60) begin
      commutate(seq[k % 6], 1'b0);
      k++;
    end
    check_eq("down_duty", 32'(duty_out), 3);
    commutate(seq[k % 6], 1'b0);
    k++;
    commutate(seq[k % 6], 1'b0);
    check_eq("down_hold", 32'(duty_out), 3);

    // Asynchronous reset mid-RUN.
    chk_run = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_duty", 32'(duty_out), 0);
    check_eq("arst_pwm_en", 32'(pwm_en), 0);
    check_eq("arst_gates", 32'({gate_h, gate_l}), 0);
    check_eq("arst_fault", 32'(fault), 0);
    check_eq("arst_state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
